// File: rtl/ghost_mode_scheduler_if.sv
// Signal bundle between game control, the ghost movers and ghost_mode_scheduler.
// Build macro GHOST_SCHED_REVERSE_EN adds the ghost_reverse pulse vector.
interface ghost_mode_scheduler_if #(
  parameter int NUM_GHOSTS = 4
);
  logic                    start_game;
  logic                    game_over;
  logic                    pellet_eaten;
  logic [NUM_GHOSTS-1:0]   ghost_eaten;
  logic [NUM_GHOSTS-1:0]   ghost_home;
  logic [NUM_GHOSTS-1:0]   ghost_release;
  logic [2*NUM_GHOSTS-1:0] ghost_mode;
  logic [NUM_GHOSTS-1:0]   ghost_eyes;
  logic                    fright_blink;
  logic                    global_phase;
  logic [1:0]              eat_score_idx;
`ifdef GHOST_SCHED_REVERSE_EN
  logic [NUM_GHOSTS-1:0]   ghost_reverse;

  modport master (
    output start_game, game_over, pellet_eaten, ghost_eaten, ghost_home,
    input  ghost_release, ghost_mode, ghost_eyes, fright_blink, global_phase,
           eat_score_idx, ghost_reverse
  );
  modport slave (
    input  start_game, game_over, pellet_eaten, ghost_eaten, ghost_home,
    output ghost_release, ghost_mode, ghost_eyes, fright_blink, global_phase,
           eat_score_idx, ghost_reverse
  );
`else
  modport master (
    output start_game, game_over, pellet_eaten, ghost_eaten, ghost_home,
    input  ghost_release, ghost_mode, ghost_eyes, fright_blink, global_phase,
           eat_score_idx
  );
  modport slave (
    input  start_game, game_over, pellet_eaten, ghost_eaten, ghost_home,
    output ghost_release, ghost_mode, ghost_eyes, fright_blink, global_phase,
           eat_score_idx
  );
`endif
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Frame-rate scheduler for ghost pen release, scatter/chase phases, fright and eyes return.
// Build macro GHOST_SCHED_REVERSE_EN adds per-ghost reversal pulses on phase change / fright.
module ghost_mode_scheduler #(
  parameter int NUM_GHOSTS     = 4,
  parameter int SCATTER_FRAMES = 420,
  parameter int CHASE_FRAMES   = 1200,
  parameter int PHASE_PAIRS    = 4,
  parameter int RELEASE_GAP    = 120,
  parameter int FRIGHT_FRAMES  = 360,
  parameter int BLINK_FRAMES   = 120
) (
  input logic                   Reset,
  input logic                   frame_clk,
  ghost_mode_scheduler_if.slave bus
);
  // state    | meaning
  // S_IDLE   | game not started, ghosts penned, counters cleared
  // S_RUN    | scatter/chase phase timer running
  // S_FRIGHT | power pellet active, phase timer paused
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FRIGHT} state_t;

  localparam int REL_MAX = (NUM_GHOSTS - 1) * RELEASE_GAP;
  localparam int REL_W   = $clog2(REL_MAX + 2);
  localparam int FR_W    = ($clog2(FRIGHT_FRAMES + 1) > 4) ? $clog2(FRIGHT_FRAMES + 1) : 4;
  localparam int PAIR_W  = $clog2(PHASE_PAIRS + 2);

  localparam logic [10:0]       SC_LAST   = 11'(SCATTER_FRAMES - 1);
  localparam logic [10:0]       CH_LAST   = 11'(CHASE_FRAMES - 1);
  localparam logic [REL_W-1:0]  REL_MAX_V = REL_W'(REL_MAX);
  localparam logic [FR_W-1:0]   FR_LOAD   = FR_W'(FRIGHT_FRAMES);
  localparam logic [FR_W-1:0]   BLINK_V   = FR_W'(BLINK_FRAMES);
  localparam logic [PAIR_W-1:0] PAIRS_V   = PAIR_W'(PHASE_PAIRS);

  localparam logic [1:0] M_PEN = 2'b00, M_SCATTER = 2'b01, M_CHASE = 2'b10, M_FRIGHT = 2'b11;

  state_t                  r_state, w_state;
  logic [10:0]             r_ph_cnt, w_ph_cnt;
  logic                    r_phase, w_phase;
  logic [PAIR_W-1:0]       r_pairs, w_pairs;
  logic [REL_W-1:0]        r_rel_cnt, w_rel_cnt;
  logic [NUM_GHOSTS-1:0]   r_release, w_release;
  logic [NUM_GHOSTS-1:0]   r_eyes, w_eyes;
  logic [NUM_GHOSTS-1:0]   r_frt, w_frt;
  logic [FR_W-1:0]         r_fr_cnt, w_fr_cnt;
  logic [1:0]              r_combo, w_combo;
  logic [1:0]              r_score, w_score;
  logic [2*NUM_GHOSTS-1:0] r_mode, w_mode;
  logic                    r_blink, w_blink;
  logic [NUM_GHOSTS-1:0]   w_eat;
  logic                    w_pellet;
  logic                    w_frz;
  int                      w_sum;

  assign w_frz = bus.game_over | ~bus.start_game;

  always_comb begin
    w_state   = r_state;
    w_ph_cnt  = r_ph_cnt;
    w_phase   = r_phase;
    w_pairs   = r_pairs;
    w_rel_cnt = r_rel_cnt;
    w_release = r_release;
    w_frt     = r_frt;
    w_fr_cnt  = r_fr_cnt;
    w_combo   = r_combo;
    w_score   = r_score;
    w_eat     = '0;
    w_pellet  = 1'b0;
    w_sum     = 0;
    w_mode    = '0;
    case (r_state)
      S_IDLE: w_state = S_RUN;
      S_RUN: begin
        // once all pairs are spent the timer stops and chase is permanent
        if (r_pairs != PAIRS_V) begin
          if (r_ph_cnt == (r_phase ? CH_LAST : SC_LAST)) begin
            w_ph_cnt = '0;
            if (!r_phase) begin
              w_phase = 1'b1;
            end else begin
              w_pairs = r_pairs + PAIR_W'(1);
              if (w_pairs != PAIRS_V) w_phase = 1'b0;
            end
          end else begin
            w_ph_cnt = r_ph_cnt + 11'd1;
          end
        end
        if (bus.pellet_eaten) begin
          w_state  = S_FRIGHT;
          w_pellet = 1'b1;
          w_fr_cnt = FR_LOAD;
          w_combo  = '0;
        end
      end
      S_FRIGHT: begin
        w_eat = bus.ghost_eaten & r_frt;
        if (|w_eat) begin
          w_sum   = int'(r_combo) + $countones(w_eat);
          w_score = r_combo;
          w_combo = (w_sum > 3) ? 2'd3 : 2'(w_sum);
        end
        w_frt = r_frt & ~w_eat;
        if (bus.pellet_eaten) begin
          w_pellet = 1'b1;
          w_fr_cnt = FR_LOAD;
          w_combo  = '0;
        end else if (r_fr_cnt == FR_W'(1)) begin
          w_state  = S_RUN;
          w_fr_cnt = '0;
          w_frt    = '0;
        end else begin
          w_fr_cnt = r_fr_cnt - FR_W'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase

    if (r_state != S_IDLE && r_rel_cnt != REL_MAX_V) w_rel_cnt = r_rel_cnt + REL_W'(1);
    if (w_state != S_IDLE)
      for (int i = 0; i < NUM_GHOSTS; i++)
        if (int'(w_rel_cnt) >= i * RELEASE_GAP) w_release[i] = 1'b1;

    // an eat lands before a same-edge pellet, so the eaten ghost is not re-frightened
    w_eyes = (r_eyes & ~bus.ghost_home) | w_eat;
    if (w_pellet) w_frt = w_release & ~w_eyes;

    for (int i = 0; i < NUM_GHOSTS; i++)
      w_mode[2*i +: 2] = !w_release[i] ? M_PEN :
                         w_frt[i]      ? M_FRIGHT :
                         (w_phase ? M_CHASE : M_SCATTER);
    w_blink = (w_state == S_FRIGHT) && (w_fr_cnt <= BLINK_V) && w_fr_cnt[3];
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_ph_cnt  <= '0;
      r_phase   <= 1'b0;
      r_pairs   <= '0;
      r_rel_cnt <= '0;
      r_release <= '0;
      r_eyes    <= '0;
      r_frt     <= '0;
      r_fr_cnt  <= '0;
      r_combo   <= '0;
      r_score   <= '0;
      r_mode    <= '0;
      r_blink   <= 1'b0;
    end else if (!w_frz) begin
      r_state   <= w_state;
      r_ph_cnt  <= w_ph_cnt;
      r_phase   <= w_phase;
      r_pairs   <= w_pairs;
      r_rel_cnt <= w_rel_cnt;
      r_release <= w_release;
      r_eyes    <= w_eyes;
      r_frt     <= w_frt;
      r_fr_cnt  <= w_fr_cnt;
      r_combo   <= w_combo;
      r_score   <= w_score;
      r_mode    <= w_mode;
      r_blink   <= w_blink;
    end
  end

  assign bus.ghost_release = r_release;
  assign bus.ghost_mode    = r_mode;
  assign bus.ghost_eyes    = r_eyes;
  assign bus.fright_blink  = r_blink;
  assign bus.global_phase  = r_phase;
  assign bus.eat_score_idx = r_score;

`ifdef GHOST_SCHED_REVERSE_EN
  logic [NUM_GHOSTS-1:0] r_rev;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)
      r_rev <= '0;
    else if (!w_frz)
      r_rev <= ((w_phase != r_phase) || w_pellet) ? (w_release & ~w_eyes) : '0;
  end

  assign bus.ghost_reverse = r_rev;
`endif
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Vector-table and scoreboard bench for ghost_mode_scheduler with reduced frame counts.
module tb_ghost_mode_scheduler;
  localparam int NG = 4;

  logic Reset;
  logic frame_clk;

  ghost_mode_scheduler_if #(.NUM_GHOSTS(NG)) gif ();

  ghost_mode_scheduler #(
    .NUM_GHOSTS(NG), .SCATTER_FRAMES(4), .CHASE_FRAMES(6), .PHASE_PAIRS(1),
    .RELEASE_GAP(2), .FRIGHT_FRAMES(8), .BLINK_FRAMES(8)
  ) dut (
    .Reset(Reset),
    .frame_clk(frame_clk),
    .bus(gif.slave)
  );

  typedef struct {
    logic       rst;
    logic       st;
    logic       ov;
    logic       pel;
    logic [3:0] eat;
    logic [3:0] home;
    logic [3:0] rel;
    logic [7:0] mode;
    logic [3:0] eyes;
    logic       blink;
    logic       ph;
    logic [1:0] sc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_no   = 0;

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic vec_t mk(input int rst, st, ov, pel, eat, home,
                              input int rel, mode, eyes, blink, ph, sc);
    vec_t v;
    v.rst = 1'(rst);  v.st = 1'(st);    v.ov = 1'(ov);     v.pel = 1'(pel);
    v.eat = 4'(eat);  v.home = 4'(home); v.rel = 4'(rel);  v.mode = 8'(mode);
    v.eyes = 4'(eyes); v.blink = 1'(blink); v.ph = 1'(ph); v.sc = 2'(sc);
    return v;
  endfunction

  function automatic void add(input int rst, st, ov, pel, eat, home,
                              input int rel, mode, eyes, blink, ph, sc);
    vecs.push_back(mk(rst, st, ov, pel, eat, home, rel, mode, eyes, blink, ph, sc));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, vec_no, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_release"}, 32'(gif.ghost_release), 32'd0);
    chk({tag, "_mode"},    32'(gif.ghost_mode),    32'd0);
    chk({tag, "_eyes"},    32'(gif.ghost_eyes),    32'd0);
    chk({tag, "_blink"},   32'(gif.fright_blink),  32'd0);
    chk({tag, "_phase"},   32'(gif.global_phase),  32'd0);
    chk({tag, "_score"},   32'(gif.eat_score_idx), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    vec_no++;
    if (v.rst) begin
      Reset = 1'b1;
      #2;
      chk_zero("reset");
      Reset = 1'b0;
    end
    gif.start_game   = v.st;
    gif.game_over    = v.ov;
    gif.pellet_eaten = v.pel;
    gif.ghost_eaten  = v.eat;
    gif.ghost_home   = v.home;
    exp_q.push_back(v);
    @(posedge frame_clk);
    #1;
    e = exp_q.pop_front();
    chk("release", 32'(gif.ghost_release), 32'(e.rel));
    chk("mode",    32'(gif.ghost_mode),    32'(e.mode));
    chk("eyes",    32'(gif.ghost_eyes),    32'(e.eyes));
    chk("blink",   32'(gif.fright_blink),  32'(e.blink));
    chk("phase",   32'(gif.global_phase),  32'(e.ph));
    chk("score",   32'(gif.eat_score_idx), 32'(e.sc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired vec=%0d", vec_no);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset            = 1'b1;
    gif.start_game   = 1'b0;
    gif.game_over    = 1'b0;
    gif.pellet_eaten = 1'b0;
    gif.ghost_eaten  = '0;
    gif.ghost_home   = '0;

    // release staggering, scatter->chase, chase becomes permanent
    add(1,1,0,0,0,0, 'h1,'h01,0,0,0,0);
    add(0,1,0,0,0,0, 'h1,'h01,0,0,0,0);
    add(0,1,0,0,0,0, 'h3,'h05,0,0,0,0);
    add(0,1,0,0,0,0, 'h3,'h05,0,0,0,0);
    add(0,1,0,0,0,0, 'h7,'h2A,0,0,1,0);
    add(0,1,0,0,0,0, 'h7,'h2A,0,0,1,0);
    for (int k = 7; k <= 18; k++) add(0,1,0,0,0,0, 'hF,'hAA,0,0,1,0);

    // fright, combo eats, eyes return, reload on the expiry edge
    add(1,1,0,0,0,0, 'h1,'h01,0,0,0,0);
    add(0,1,0,0,0,0, 'h1,'h01,0,0,0,0);
    add(0,1,0,0,0,0, 'h3,'h05,0,0,0,0);
    add(0,1,0,0,0,0, 'h3,'h05,0,0,0,0);
    add(0,1,0,0,0,0, 'h7,'h2A,0,0,1,0);
    add(0,1,0,0,0,0, 'h7,'h2A,0,0,1,0);
    add(0,1,0,0,0,0, 'hF,'hAA,0,0,1,0);
    add(0,1,0,1,0,0, 'hF,'hFF,0,1,1,0);
    add(0,1,0,0,0,0, 'hF,'hFF,0,0,1,0);
    add(0,1,0,0,1,0, 'hF,'hFE,'h1,0,1,0);
    add(0,1,0,0,6,0, 'hF,'hEA,'h7,0,1,1);
    add(0,1,0,0,8,0, 'hF,'hAA,'hF,0,1,3);
    add(0,1,0,0,1,1, 'hF,'hAA,'hE,0,1,3);
    add(0,1,0,0,0,6, 'hF,'hAA,'h8,0,1,3);
    add(0,1,0,0,0,0, 'hF,'hAA,'h8,0,1,3);
    add(0,1,0,1,0,0, 'hF,'hBF,'h8,1,1,3);
    add(0,1,0,0,4,0, 'hF,'hAF,'hC,0,1,0);
    for (int k = 0; k < 6; k++) add(0,1,0,0,0,0, 'hF,'hAF,'hC,0,1,0);
    add(0,1,0,0,0,0, 'hF,'hAA,'hC,0,1,0);
    add(0,1,0,0,0,0, 'hF,'hAA,'hC,0,1,0);

    // fright during scatter pauses the phase timer; releases continue
    add(1,1,0,0,0,0, 'h1,'h01,0,0,0,0);
    add(0,1,0,0,0,0, 'h1,'h01,0,0,0,0);
    add(0,1,0,1,0,0, 'h3,'h0F,0,1,0,0);
    add(0,1,0,0,0,0, 'h3,'h0F,0,0,0,0);
    add(0,1,0,0,0,0, 'h7,'h1F,0,0,0,0);
    add(0,1,0,0,0,0, 'h7,'h1F,0,0,0,0);
    for (int k = 0; k < 4; k++) add(0,1,0,0,0,0, 'hF,'h5F,0,0,0,0);
    add(0,1,0,0,0,0, 'hF,'h55,0,0,0,0);
    add(0,1,0,0,0,0, 'hF,'h55,0,0,0,0);
    add(0,1,0,0,0,0, 'hF,'hAA,0,0,1,0);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // eat+pellet same edge, game_over freeze mid-fright, async reset, start gating
    run_vec(mk(1,1,0,0,0,0, 'h1,'h01,0,0,0,0));
    run_vec(mk(0,1,0,1,0,0, 'h1,'h03,0,1,0,0));
    run_vec(mk(0,1,0,1,1,0, 'h3,'h0D,'h1,1,0,0));
    run_vec(mk(0,1,0,0,0,0, 'h3,'h0D,'h1,0,0,0));
    for (int k = 0; k < 5; k++) run_vec(mk(0,1,1,1,0,1, 'h3,'h0D,'h1,0,0,0));
    run_vec(mk(0,1,0,0,0,0, 'h7,'h1D,'h1,0,0,0));
    #2;
    Reset = 1'b1;
    #1;
    chk_zero("async_reset");
    run_vec(mk(1,0,0,0,0,0, 0,0,0,0,0,0));
    run_vec(mk(0,0,0,0,0,0, 0,0,0,0,0,0));
    run_vec(mk(0,1,0,0,0,0, 'h1,'h01,0,0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
